// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and defaults for the serial sequence transmitter.
package fsm_seq_pkg;
  localparam int STATE_W     = 2;
  localparam int DEF_SEQ_LEN = 8;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_SEND = 2'd1;
  localparam logic [STATE_W-1:0] S_GAP  = 2'd2;

  // ST_BAD is never entered on purpose; it exists so recovery is explicit.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = S_IDLE,
    ST_SEND = S_SEND,
    ST_GAP  = S_GAP,
    ST_BAD  = 2'd3
  } state_e;
endpackage

// File: rtl/fsm_seq_generator_if.sv
// Request handshake and serial output bundle for fsm_seq_generator.
interface fsm_seq_generator_if
  import fsm_seq_pkg::*;
#(
  parameter int SEQ_LEN   = DEF_SEQ_LEN,
  parameter int CNT_WIDTH = 4
);
  logic                 start_valid;
  logic                 start_ready;
  logic [SEQ_LEN-1:0]   pattern;
  logic [CNT_WIDTH-1:0] repeat_cnt;
  logic                 abort;
  logic                 seq_out;
  logic                 seq_valid;
  logic                 busy;
  logic                 done;
  logic [STATE_W-1:0]   curr_state_p;

  modport master (
    output start_valid, pattern, repeat_cnt, abort,
    input  start_ready, seq_out, seq_valid, busy, done, curr_state_p
  );

  modport slave (
    input  start_valid, pattern, repeat_cnt, abort,
    output start_ready, seq_out, seq_valid, busy, done, curr_state_p
  );
endinterface

// File: rtl/fsm_seq_piso.sv
// Parallel-load, LSB-first serial-out shift register with a registered output
// bit that drops to 0 whenever neither load nor shift is requested.
module fsm_seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);
  logic [W-1:0] sr_q, sr_d;
  logic         sout_q, sout_d;

  always_comb begin
    sr_d   = sr_q;
    sout_d = 1'b0;
    if (load) begin
      sout_d = din[0];
      sr_d   = {1'b0, din[W-1:1]};
    end else if (shift) begin
      sout_d = sr_q[0];
      sr_d   = {1'b0, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      sout_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      sout_q <= sout_d;
    end
  end

  assign sout = sout_q;
endmodule

// File: rtl/fsm_seq_generator.sv
// Serial sequence transmitter: sends a captured pattern LSB first, repeated
// R times with GAP_LEN idle cycles between repetitions.
module fsm_seq_generator
  import fsm_seq_pkg::*;
#(
  parameter int SEQ_LEN   = DEF_SEQ_LEN,
  parameter int CNT_WIDTH = 4,
  parameter int GAP_LEN   = 2
) (
  input logic              clock0,
  input logic              reset,
  fsm_seq_generator_if.slave bus
);
  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] rep_q, rep_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [SEQ_LEN-1:0]   pattern_q, pattern_d;
  logic                 seq_valid_q, seq_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept, eor, more, load, shift;
  logic [SEQ_LEN-1:0]   piso_din;
  logic                 seq_out_w;

  // Output flops are computed from next state so the bit shown in a cycle
  // belongs to the state the FSM occupies in that same cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    pattern_d = pattern_q;
    accept    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    done_d    = 1'b0;
    eor       = (idx_q == IDX_LAST);
    more      = (rep_q > CNT_WIDTH'(1));

    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          accept    = 1'b1;
          load      = 1'b1;
          state_d   = ST_SEND;
          idx_d     = '0;
          pattern_d = bus.pattern;
          rep_d     = (bus.repeat_cnt == '0) ? CNT_WIDTH'(1) : bus.repeat_cnt;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!eor) begin
          idx_d = idx_q + 1'b1;
          shift = 1'b1;
        end else if (more) begin
          rep_d = rep_q - 1'b1;
          idx_d = '0;
          if (GAP_LEN == 0) begin
            load = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    piso_din    = accept ? bus.pattern : pattern_q;
    seq_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      pattern_q   <= '0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      pattern_q   <= pattern_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fsm_seq_piso #(.W(SEQ_LEN)) u_piso (
    .clk   (clock0),
    .rst   (reset),
    .load  (load),
    .shift (shift),
    .din   (piso_din),
    .sout  (seq_out_w)
  );

  assign bus.start_ready  = (state_q == ST_IDLE);
  assign bus.seq_out      = seq_out_w;
  assign bus.seq_valid    = seq_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.curr_state_p = state_q;
endmodule
